// File: rtl/bsg_scatter_gather_sequencer_pkg.sv
// Shared types and helpers for the scatter/gather sequencer.
package bsg_scatter_gather_sequencer_pkg;

  typedef enum logic {IDLE, DRAIN} state_e;

  // Index width for an n-entry lane set (never zero).
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/bsg_sg_pick_lowest.sv
// Combinational picker: selects the lowest out_els_p set mask bits, one per slot,
// reporting one-hot selects, lane indices, the count and the leftover mask.
module bsg_sg_pick_lowest #(
  parameter int els_p     = 4,
  parameter int out_els_p = 2,
  parameter int lid_w     = 2,
  parameter int cnt_w     = 2
) (
  input  logic [els_p-1:0]                      mask,
  output logic [out_els_p-1:0][els_p-1:0]       sel,
  output logic [out_els_p-1:0][lid_w-1:0]       lane_id,
  output logic [cnt_w-1:0]                      cnt,
  output logic [els_p-1:0]                      rest
);

  logic [lid_w-1:0] pick;
  logic             hit;

  always_comb begin
    rest    = mask;
    sel     = '0;
    lane_id = '0;
    cnt     = '0;
    pick    = '0;
    hit     = 1'b0;
    for (int s = 0; s < out_els_p; s++) begin
      hit  = 1'b0;
      pick = '0;
      // Descending scan so the lowest remaining bit is the one kept.
      for (int k = els_p - 1; k >= 0; k--) begin
        if (rest[k]) begin
          hit  = 1'b1;
          pick = lid_w'(k);
        end
      end
      if (hit) begin
        sel[s][pick] = 1'b1;
        lane_id[s]   = pick;
        rest[pick]   = 1'b0;
        cnt          = cnt + cnt_w'(1);
      end
    end
  end

endmodule

// File: rtl/bsg_scatter_gather_sequencer.sv
// Compacts a masked lane vector into dense beats of up to out_els_p lanes,
// lowest lane first. Optional perf counters: BSG_SCATTER_GATHER_SEQUENCER_PERF_EN.
module bsg_scatter_gather_sequencer
  import bsg_scatter_gather_sequencer_pkg::*;
#(
  parameter int els_p     = 4,
  parameter int width_p   = 8,
  parameter int out_els_p = 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  v_i,
  input  logic [els_p-1:0]                      vec_i,
  input  logic [els_p*width_p-1:0]              data_i,
  output logic                                  ready_o,
  output logic                                  v_o,
  output logic [out_els_p*width_p-1:0]          data_o,
  output logic [out_els_p*$clog2(els_p)-1:0]    lane_id_o,
  output logic [$clog2(out_els_p+1)-1:0]        cnt_o,
  output logic                                  last_o,
  input  logic                                  ready_i
`ifdef BSG_SCATTER_GATHER_SEQUENCER_PERF_EN
  ,
  output logic [31:0]                           beats_o,
  output logic [15:0]                           drops_o
`endif
);

  localparam int lid_w = lane_w(els_p);
  localparam int cnt_w = $clog2(out_els_p + 1);

  state_e                              state, state_n;
  logic [els_p-1:0]                    mask_q, mask_n;
  logic [els_p-1:0][width_p-1:0]       data_q, data_n;

  logic [out_els_p-1:0][els_p-1:0]     sel;
  logic [out_els_p-1:0][lid_w-1:0]     lane_id;
  logic [out_els_p-1:0][width_p-1:0]   slot_d;
  logic [cnt_w-1:0]                    cnt;
  logic [els_p-1:0]                    rest;
  logic                                last, accept, xfer;

  bsg_sg_pick_lowest #(
    .els_p(els_p), .out_els_p(out_els_p), .lid_w(lid_w), .cnt_w(cnt_w)
  ) pick (
    .mask(mask_q), .sel(sel), .lane_id(lane_id), .cnt(cnt), .rest(rest)
  );

  // AND-OR mux: each slot has at most one select bit set.
  always_comb begin
    slot_d = '0;
    for (int s = 0; s < out_els_p; s++)
      for (int k = 0; k < els_p; k++)
        if (sel[s][k]) slot_d[s] = slot_d[s] | data_q[k];
  end

  assign last      = popcount(64'(mask_q)) <= 32'(out_els_p);
  assign v_o       = (state == DRAIN);
  assign last_o    = v_o & last;
  assign data_o    = slot_d;
  assign lane_id_o = lane_id;
  assign cnt_o     = cnt;
  assign xfer      = v_o & ready_i;
  // Accepting during the final beat's transfer gives back-to-back vectors.
  assign ready_o   = (state == IDLE) | (xfer & last);
  assign accept    = v_i & ready_o;

  always_comb begin
    state_n = state;
    mask_n  = mask_q;
    data_n  = data_q;
    if (accept) begin
      state_n = (vec_i != '0) ? DRAIN : IDLE;
      mask_n  = vec_i;
      data_n  = data_i;
    end else if (xfer) begin
      state_n = last ? IDLE : DRAIN;
      mask_n  = rest;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= IDLE;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      mask_q <= mask_n;
      data_q <= data_n;
    end
  end

`ifdef BSG_SCATTER_GATHER_SEQUENCER_PERF_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beats_o <= '0;
      drops_o <= '0;
    end else begin
      if (xfer && beats_o != 32'hFFFF_FFFF) beats_o <= beats_o + 32'd1;
      if (accept && vec_i == '0 && drops_o != 16'hFFFF) drops_o <= drops_o + 16'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule
